// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding for the unified I/D memory port arbiter
package mem_port_arbiter_pkg;
  localparam int ARB_OWNER_W = 2;
  typedef enum logic [ARB_OWNER_W-1:0] {IDLE, I_WAIT, D_WAIT} arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and RAM port signals of the arbiter (slave = arbiter side)
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              if_req, if_gnt, if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we, d_gnt, d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              stall_if, stall_mem;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter_arb_priority.sv
// arb_priority: combinational winner select, data first unless fetch is forced
module arb_priority (
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic force_if_i,
  output logic if_gnt_o,
  output logic d_gnt_o
);
  // the older instruction in MEM wins a tie unless the fetch side has starved
  always_comb begin
    if_gnt_o = if_req_i & (~d_req_i | force_if_i);
    d_gnt_o  = d_req_i & ~(if_req_i & force_if_i);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sync RAM between IF and MEM; ARB_FAIRNESS_EN adds IF anti-starvation
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  arb_state_t state_q, state_d;
  logic       we_q, we_d;
  logic       if_gnt, d_gnt, force_if;

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

  arb_priority u_prio (
    .if_req_i  (bus.if_req),
    .d_req_i   (bus.d_req),
    .force_if_i(force_if),
    .if_gnt_o  (if_gnt),
    .d_gnt_o   (d_gnt)
  );

`ifdef ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // consecutive fetch denials, cleared when IF wins or withdraws, saturating at the limit
  always_comb begin
    force_if = cnt_q == CNT_W'(STARVE_MAX);
    cnt_d    = (!bus.if_req || if_gnt) ? '0 : force_if ? cnt_q : cnt_q + 1'b1;
  end
  // starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign force_if = 1'b0;
`endif

  // next state follows the winner; outputs decode from the state of the access in flight
  always_comb begin
    state_d       = d_gnt ? D_WAIT : if_gnt ? I_WAIT : IDLE;
    we_d          = d_gnt & bus.d_we;
    bus.if_gnt    = if_gnt;
    bus.d_gnt     = d_gnt;
    bus.stall_if  = bus.if_req & ~if_gnt;
    bus.stall_mem = bus.d_req & ~d_gnt;
    bus.mem_en    = (if_gnt | d_gnt) & ~rst;
    bus.mem_we    = d_gnt & bus.d_we;
    bus.mem_addr  = d_gnt ? bus.d_addr : bus.if_addr;
    bus.mem_wdata = bus.d_wdata;
    bus.if_valid  = state_q == I_WAIT;
    bus.if_rdata  = (state_q == I_WAIT) ? bus.mem_rdata : '0;
    bus.d_valid   = state_q == D_WAIT;
    bus.d_rdata   = (state_q == D_WAIT && !we_q) ? bus.mem_rdata : '0;
  end

  // state and store flag of the access in flight; reset discards it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the unified memory port arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  logic [31:0] if_q [$];
  logic [31:0] d_q [$];
  logic [31:0] sb_if_exp, sb_d_exp;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter #(.STARVE_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr[9:2]];
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if_q.delete();
      d_q.delete();
    end else begin
      if (bus.if_valid) begin
        checks++;
        if (if_q.size() == 0) begin
          errors++;
          $display("FAIL sb_if: unexpected if_valid, rdata=%h", bus.if_rdata);
        end else begin
          sb_if_exp = if_q.pop_front();
          if (bus.if_rdata !== sb_if_exp) begin
            errors++;
            $display("FAIL sb_if: if_rdata=%h expected %h", bus.if_rdata, sb_if_exp);
          end
        end
      end
      if (bus.d_valid) begin
        checks++;
        if (d_q.size() == 0) begin
          errors++;
          $display("FAIL sb_d: unexpected d_valid, rdata=%h", bus.d_rdata);
        end else begin
          sb_d_exp = d_q.pop_front();
          if (bus.d_rdata !== sb_d_exp) begin
            errors++;
            $display("FAIL sb_d: d_rdata=%h expected %h", bus.d_rdata, sb_d_exp);
          end
        end
      end
      if (bus.if_gnt) if_q.push_back(ref_mem[bus.if_addr[9:2]]);
      if (bus.d_gnt) begin
        if (bus.d_we) begin
          d_q.push_back(32'h0);
          ref_mem[bus.d_addr[9:2]] = bus.d_wdata;
        end else begin
          d_q.push_back(ref_mem[bus.d_addr[9:2]]);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.if_req = 1'b1; bus.d_req = 1'b1; bus.d_addr = 32'h10;
    repeat (2) @(negedge clk);
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b want 0", bus.mem_en); end
    checks++; if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: if=%b d=%b want 0 0", bus.if_valid, bus.d_valid); end
    checks++; if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: if=%h d=%h want 0 0", bus.if_rdata, bus.d_rdata); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want IDLE", dut.state_q); end
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0) begin errors++; $display("FAIL rst_release: if_valid=%b d_valid=%b want 0 0", bus.if_valid, bus.d_valid); end
  endtask

  task automatic test_fetch();
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h4;
    @(negedge clk);
    checks++; if (bus.if_gnt !== 1'b1 || bus.stall_if !== 1'b0) begin errors++; $display("FAIL fetch_gnt: gnt=%b stall=%b want 1 0", bus.if_gnt, bus.stall_if); end
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h4) begin errors++; $display("FAIL fetch_mem: en=%b we=%b addr=%h want 1 0 4", bus.mem_en, bus.mem_we, bus.mem_addr); end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h2008_0005) begin errors++; $display("FAIL fetch_data: valid=%b rdata=%h want 1 20080005", bus.if_valid, bus.if_rdata); end
  endtask

  task automatic test_contention();
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin errors++; $display("FAIL cont_gnt: d=%b if=%b want 1 0", bus.d_gnt, bus.if_gnt); end
    checks++; if (bus.stall_if !== 1'b1 || bus.stall_mem !== 1'b0) begin errors++; $display("FAIL cont_stall: if=%b mem=%b want 1 0", bus.stall_if, bus.stall_mem); end
    checks++; if (bus.mem_addr !== 32'h10) begin errors++; $display("FAIL cont_addr: got %h want 10", bus.mem_addr); end
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cont_data: valid=%b rdata=%h want 1 deadbeef", bus.d_valid, bus.d_rdata); end
    checks++; if (bus.if_gnt !== 1'b1 || bus.stall_if !== 1'b0) begin errors++; $display("FAIL cont_if_gnt: gnt=%b stall=%b want 1 0", bus.if_gnt, bus.stall_if); end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'hA000_0002) begin errors++; $display("FAIL cont_fetch: valid=%b rdata=%h want 1 a0000002", bus.if_valid, bus.if_rdata); end
  endtask

  task automatic test_store_load();
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL st_issue: gnt=%b we=%b wdata=%h want 1 1 12345678", bus.d_gnt, bus.mem_we, bus.mem_wdata); end
    @(posedge clk); #1;
    bus.d_we = 1'b0;
    @(negedge clk);
    checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h0) begin errors++; $display("FAIL st_ack: valid=%b rdata=%h want 1 0", bus.d_valid, bus.d_rdata); end
    checks++; if (bus.mem_we !== 1'b0 || bus.d_gnt !== 1'b1) begin errors++; $display("FAIL ld_issue: we=%b gnt=%b want 0 1", bus.mem_we, bus.d_gnt); end
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h1234_5678) begin errors++; $display("FAIL ld_data: valid=%b rdata=%h want 1 12345678", bus.d_valid, bus.d_rdata); end
    @(negedge clk);
    checks++; if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL ld_single: d_valid=%b want 0", bus.d_valid); end
  endtask

  task automatic test_fairness();
    logic exp_if;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'hC;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h30;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      exp_if = FAIR && (i == 4);
      checks++; if (bus.if_gnt !== exp_if || bus.d_gnt !== !exp_if) begin errors++; $display("FAIL fair_cycle%0d: if_gnt=%b d_gnt=%b want %b %b", i, bus.if_gnt, bus.d_gnt, exp_if, !exp_if); end
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    @(negedge clk);
    checks++; if (bus.if_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b want 1", bus.if_gnt); end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL rmid_flush: if_valid=%b state=%0d want 0 IDLE", bus.if_valid, dut.state_q); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_pulse: if_valid=%b want 0", bus.if_valid); end
    end
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h4;
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h2008_0005) begin errors++; $display("FAIL rmid_refetch: valid=%b rdata=%h want 1 20080005", bus.if_valid, bus.if_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bb_exp [3];
    bb_exp = '{32'hA000_0000, 32'h2008_0005, 32'hA000_0002};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.if_req = i < 3;
      bus.if_addr = 32'(i * 4);
      @(negedge clk);
      checks++; if (bus.if_gnt !== (i < 3)) begin errors++; $display("FAIL b2b_gnt%0d: got %b want %b", i, bus.if_gnt, i < 3); end
      if (i > 0) begin
        checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== bb_exp[i-1]) begin errors++; $display("FAIL b2b_data%0d: valid=%b rdata=%h want 1 %h", i, bus.if_valid, bus.if_rdata, bb_exp[i-1]); end
      end
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: if_valid=%b want 0", bus.if_valid); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hA000_0000 | 32'(i);
    ram[1] = 32'h2008_0005;
    ram[4] = 32'hDEAD_BEEF;
    ref_mem = ram;
    bus.mem_rdata = '0;
    test_reset();
    test_fetch();
    test_contention();
    test_store_load();
    test_fairness();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++; if (if_q.size() != 0 || d_q.size() != 0) begin errors++; $display("FAIL sb_drain: if pending=%0d d pending=%0d want 0 0", if_q.size(), d_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port synchronous RAM between the instruction-fetch stage and the MEM stage of the 5-stage pipeline, enabling a unified instruction/data memory. Each requester uses a request/grant handshake, with data returned one cycle after grant. Denied requesters get stall outputs so the pipeline control can freeze IF/ID or EX/MEM. The block sits between the IF/MEM stages and the RAM, alongside the hazard logic.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- STARVE_MAX, 4, consecutive IF denials before IF is forced to win (fairness build only)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until granted
- if_addr  in  ADDR_W  fetch address (pc_if)
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_valid  out  1  fetch data valid (registered, cycle after if_gnt)
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request (MemRead or MemWrite in MEM)
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address (alu_out_ex_mem)
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data granted this cycle (combinational)
- d_valid  out  1  load data valid / store acknowledged (registered)
- d_rdata  out  DATA_W  load data
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en
- stall_if  out  1  if_req & ~if_gnt
- stall_mem  out  1  d_req & ~d_gnt

## Operation
- FSM states: IDLE (nothing in flight), I_WAIT (fetch in flight), D_WAIT (data access in flight).
- A grant can issue in any state, so back-to-back accesses sustain one access per cycle.
- Arbitration each cycle:
  - Only one request → that requester wins.
  - Both requesting → data wins (the older instruction first), except when fairness forces IF.
- On a grant, mem_* are driven from the winner in the same cycle, and mem_en=1.
- Next state:
  - Data granted → D_WAIT.
  - Fetch granted → I_WAIT.
  - No grant → IDLE.
- In I_WAIT: if_valid=1 and if_rdata=mem_rdata.
- In D_WAIT: d_valid=1; d_rdata=mem_rdata for a load, 0 for a store.
- Only the winner sees gnt=1; the loser's request must stay stable, and its stall_* is asserted.
- mem_we = d_we only on a data grant, otherwise 0.
- Addresses pass through unmodified; the RAM does its own word indexing.

## Timing
- Reset values: state IDLE, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, starvation counter 0.
  - Combinational outputs follow their inputs.
  - mem_en=0 while rst is high.
- Latency: gnt at cycle N → valid at N+1. There is exactly one valid pulse per grant.
- Store: RAM is written at the edge ending cycle N; d_valid pulses at N+1.
- Reset mid-access: the in-flight result is discarded, and no valid pulse occurs after rst deasserts.
- Request dropped without a grant is legal; nothing is issued for it.

## Configuration
- ARB_FAIRNESS_EN defined:
  - A counter of width $clog2(STARVE_MAX+1) increments each cycle IF is denied while if_req=1.
  - It clears on if_gnt, or when if_req=0.
  - When the count equals STARVE_MAX and both requesters are active, IF wins and d_gnt=0.
  - The counter saturates at STARVE_MAX.
- ARB_FAIRNESS_EN undefined:
  - Strict data priority; the counter is not built.
  - IF can starve indefinitely under continuous d_req.

## Structure
- Shared package (with the existing `definitions.vh` constants):
  - arb_state_t enum {IDLE, I_WAIT, D_WAIT}.
  - ARB_OWNER width constant.
- One sub-module, arb_priority: combinational winner select (inputs if_req, d_req, force_if; outputs if_gnt, d_gnt).
- FSM, output registers, and the counter stay in mem_port_arbiter.

## Test plan
- Fetch only: if_req=1, if_addr=0x0000_0004, RAM[1]=0x2008_0005 → if_gnt=1 in the same cycle; next cycle if_valid=1, if_rdata=0x2008_0005; stall_if=0.
- Contention: if_req=d_req=1, d_we=0, d_addr=0x10, RAM[4]=0xDEAD_BEEF → d_gnt=1, stall_if=1. Next cycle d_rdata=0xDEAD_BEEF and if_gnt=1.
- Store then load: d_we=1, d_addr=0x20, d_wdata=0x1234_5678, then a load from 0x20 → d_valid pulses on both; load returns 0x1234_5678.
- Starvation (ARB_FAIRNESS_EN, STARVE_MAX=4): both requests held high → d_gnt for 4 cycles, then if_gnt on the 5th, then the counter returns to 0. Without the macro, d_gnt every cycle.
- Reset mid-access: assert rst the cycle after if_gnt → if_valid stays 0 and state is IDLE; after release, a fresh fetch completes normally.
- Back-to-back fetches at 0x0, 0x4, 0x8 → if_valid high for 3 consecutive cycles with the matching words.
